sprite_line_scheduler: RTL and testbench
========================================

// Module: sprite_line_scheduler
// PURPOSE
//  Per-scanline sequencer for the sprite pipeline: on each line_start it scans OAM,
//  builds the secondary array of sprites hitting line_number, then hands the OAM bus
//  to the sprite drawer and holds its enable until the drawer finishes. It owns the
//  OAM read port mux select and signals line completion to the video timing logic.
// PARAMETERS
//  OAM_ADDR_SIZE      8    OAM word address width
//  OAM_DATA_SIZE      32   OAM word width (ypos [27:18], enable [31])
//  OAM_ENTRIES        128  entries scanned per line, addresses 0..OAM_ENTRIES-1
//  SECOND_ARRAY_SIZE  32   max sprites per line
//  SPRITE_HEIGHT      16   sprite rows; power of two
//  DISPLAY_HEIGHT     480  visible lines; LINE_NUMBER_WIDTH = $clog2(DISPLAY_HEIGHT)
// PORTS
//  clk            in   1                    clock
//  rst            in   1                    reset rst, asynchronous, active-high
//  line_start     in   1                    one-cycle pulse: begin processing line_number
//  line_number    in   LINE_NUMBER_WIDTH    line to evaluate; sampled on accepted line_start
//  oam_a          out  OAM_ADDR_SIZE        OAM read address (valid when oam_sel=1)
//  oam_d          in   OAM_DATA_SIZE        OAM read data, 1-cycle synchronous latency
//  oam_sel        out  1                    1: scheduler owns OAM port, 0: drawer owns it
//  second_array   out  SECOND_ARRAY_SIZE x (OAM_ADDR_SIZE+1)  {addr, valid} per slot
//  drawer_enable  out  1                    enable to sprite drawer
//  drawer_done    in   1                    drawer reports end of list
//  busy           out  1                    1 in any state but IDLE
//  line_ready     out  1                    one-cycle pulse: line buffer complete
//  sprite_count   out  $clog2(SECOND_ARRAY_SIZE)+1  hits found on current line
//  overflow       out  1                    >SECOND_ARRAY_SIZE hits on current line
//  late_err       out  1                    sticky: line_start arrived while busy
// BEHAVIOUR
//  Reset: state IDLE; oam_a=0, oam_sel=0, second_array all 0, drawer_enable=0,
//   busy=0, line_ready=0, sprite_count=0, overflow=0, late_err=0. Reset mid-line aborts.
//  IDLE: line_start -> latch line_number, clear second_array, sprite_count, overflow,
//   late_err; issue_idx=0; -> SCAN next cycle.
//  SCAN: oam_sel=1; oam_a=issue_idx, issue_idx++ each cycle (one address per cycle).
//   Data for address k evaluated the cycle after k issued. Hit: oam_d[31]=1 AND
//   (line - ypos) mod 2^10 < SPRITE_HEIGHT (10-bit unsigned subtract, so ypos > line
//   never hits). Hit with count<SIZE: slot[count]={k,1'b1}, count++.
//   Hit with count==SIZE: overflow=1, end scan immediately.
//   Scan ends after evaluating address OAM_ENTRIES-1 (OAM_ENTRIES+1 cycles in SCAN).
//   End -> DRAW; if count==0 -> DONE directly (drawer never enabled).
//  DRAW: oam_sel=0, oam_a held 0, drawer_enable=1; second_array frozen.
//   Exit to DONE on drawer_done=1, or after count+2 cycles (guards full array, which has
//   no invalid terminator), whichever first; drawer_enable drops the cycle after exit.
//  DONE: one cycle, line_ready=1, drawer_enable=0, oam_sel=0; -> IDLE.
//  line_start while busy: ignored, late_err=1 (cleared on next accepted line_start).
//  line_start in DONE cycle also ignored (sets late_err); accepted only in IDLE.
//  sprite_count/overflow/second_array hold until next accepted line_start.
//  Priority: lowest OAM address occupies lowest slot; drawer order is slot order.
// TESTING
//  1 Reset mid-SCAN (rst pulse) -> all outputs at reset values next cycle, state IDLE.
//  2 OAM empty (all enable=0), line_start line=10 -> SCAN 129 cycles, no DRAW,
//    line_ready pulse, count=0, drawer_enable never 1.
//  3 Entries 3 (y=5) and 70 (y=20), line=20 -> slot0={3,1}, slot1={70,1}, count=2;
//    entry 3 hits (20-5=15), y=21 would not; drawer_done at 3rd DRAW cycle -> line_ready.
//  4 Sprite y=470, line=5 -> no hit (wrap subtract 559 >= 16); y=0,line=15 hits,line=16 misses.
//  5 40 enabled hits, line=100 -> 32 slots filled, overflow=1 at 33rd hit, scan ends
//    early; drawer_done held 0 -> DRAW exits after 34 cycles.
//  6 line_start during DRAW -> ignored, late_err=1; next IDLE line_start clears it.

Source files
------------

// File: rtl/sprite_line_scheduler_if.sv
// Scanline sequencer <-> video timing / OAM / sprite drawer signal bundle.
interface sprite_line_scheduler_if #(
    parameter int OAM_ADDR_SIZE     = 8,
    parameter int OAM_DATA_SIZE     = 32,
    parameter int SECOND_ARRAY_SIZE = 32,
    parameter int DISPLAY_HEIGHT    = 480
);
    localparam int LINE_NUMBER_WIDTH = $clog2(DISPLAY_HEIGHT);
    localparam int COUNT_WIDTH       = $clog2(SECOND_ARRAY_SIZE) + 1;

    logic                                              line_start;
    logic [LINE_NUMBER_WIDTH-1:0]                      line_number;
    logic [OAM_ADDR_SIZE-1:0]                          oam_a;
    logic [OAM_DATA_SIZE-1:0]                          oam_d;
    logic                                              oam_sel;
    logic [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0]     second_array;
    logic                                              drawer_enable;
    logic                                              drawer_done;
    logic                                              busy;
    logic                                              line_ready;
    logic [COUNT_WIDTH-1:0]                            sprite_count;
    logic                                              overflow;
    logic                                              late_err;

    modport master (
        output line_start, line_number, oam_d, drawer_done,
        input  oam_a, oam_sel, second_array, drawer_enable, busy,
               line_ready, sprite_count, overflow, late_err
    );

    modport slave (
        input  line_start, line_number, oam_d, drawer_done,
        output oam_a, oam_sel, second_array, drawer_enable, busy,
               line_ready, sprite_count, overflow, late_err
    );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline OAM scan into a secondary sprite array, then hands the OAM port
// to the sprite drawer until it finishes and pulses line_ready.
module sprite_line_scheduler #(
    parameter int OAM_ADDR_SIZE     = 8,
    parameter int OAM_DATA_SIZE     = 32,
    parameter int OAM_ENTRIES       = 128,
    parameter int SECOND_ARRAY_SIZE = 32,
    parameter int SPRITE_HEIGHT     = 16,
    parameter int DISPLAY_HEIGHT    = 480
) (
    input logic clk,
    input logic rst,
    sprite_line_scheduler_if.slave bus
);
    localparam int LW = $clog2(DISPLAY_HEIGHT);
    localparam int CW = $clog2(SECOND_ARRAY_SIZE) + 1;
    localparam int IW = $clog2(OAM_ENTRIES + 1);
    localparam int SW = OAM_ADDR_SIZE + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAW, DONE} state_t;

    state_t                               state, state_nx;
    logic [LW-1:0]                        line_q;
    logic [IW-1:0]                        issue_idx;
    logic [CW-1:0]                        count;
    logic [CW-1:0]                        draw_cnt;
    logic [SECOND_ARRAY_SIZE-1:0][SW-1:0] slots;
    logic                                 ovf;
    logic                                 late;

    logic [9:0]               dy;
    logic                     evaluating;
    logic                     hit;
    logic                     full;
    logic                     scan_end;
    logic                     draw_exit;
    logic [OAM_ADDR_SIZE-1:0] eval_addr;

    // Read data lags the address by one cycle, so SCAN cycle k evaluates entry k-1.
    assign evaluating = (state == SCAN) && (issue_idx != '0);
    assign eval_addr  = OAM_ADDR_SIZE'(issue_idx - 1'b1);
    assign dy         = 10'(line_q) - bus.oam_d[27:18];
    assign hit        = evaluating && bus.oam_d[31] && (dy < 10'(SPRITE_HEIGHT));
    assign full       = (count == CW'(SECOND_ARRAY_SIZE));
    assign scan_end   = evaluating && ((hit && full) || (issue_idx == IW'(OAM_ENTRIES)));
    // A full array has no invalid terminator, so bound DRAW at count+2 cycles.
    assign draw_exit  = (state == DRAW) && (bus.drawer_done || (draw_cnt == count + CW'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.line_start) state_nx = SCAN;
            SCAN: if (scan_end) state_nx = (count == '0 && !hit) ? DONE : DRAW;
            DRAW: if (draw_exit) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q    <= '0;
            issue_idx <= '0;
            count     <= '0;
            draw_cnt  <= '0;
            slots     <= '0;
            ovf       <= 1'b0;
            late      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.line_start) begin
                    line_q    <= bus.line_number;
                    issue_idx <= '0;
                    count     <= '0;
                    slots     <= '0;
                    ovf       <= 1'b0;
                    late      <= 1'b0;
                end
                SCAN: begin
                    issue_idx <= issue_idx + 1'b1;
                    draw_cnt  <= '0;
                    if (hit && !full) begin
                        slots[count[CW-2:0]] <= {eval_addr, 1'b1};
                        count                <= count + 1'b1;
                    end
                    if (hit && full) ovf <= 1'b1;
                end
                DRAW: draw_cnt <= draw_cnt + 1'b1;
                default: ;
            endcase
            if (bus.line_start && state != IDLE) late <= 1'b1;
        end
    end

    assign bus.oam_sel       = (state == SCAN);
    assign bus.oam_a         = bus.oam_sel ? OAM_ADDR_SIZE'(issue_idx) : '0;
    assign bus.drawer_enable = (state == DRAW);
    assign bus.busy          = (state != IDLE);
    assign bus.line_ready    = (state == DONE);
    assign bus.second_array  = slots;
    assign bus.sprite_count  = count;
    assign bus.overflow      = ovf;
    assign bus.late_err      = late;
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Randomized bench for sprite_line_scheduler against a list-building reference model.
module tb_sprite_line_scheduler;
    localparam int N  = 128;
    localparam int S  = 32;
    localparam int SW = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sprite_line_scheduler_if bus ();
    sprite_line_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] oam [256];
    always @(posedge clk) bus.oam_d <= oam[bus.oam_a];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input bit en, input int y);
        logic [31:0] w;
        w        = $urandom;
        w[31]    = en;
        w[27:18] = y[9:0];
        return w;
    endfunction

    task automatic clear_oam();
        for (int i = 0; i < 256; i++) oam[i] = mk(1'b0, int'($urandom_range(0, 1023)));
    endtask

    // Walk OAM in address order; first S hits fill slots, the next hit flags overflow.
    task automatic model(input int line, output logic [287:0] slots, output int cnt,
                         output bit ovf, output int scan_cyc);
        slots = '0; cnt = 0; ovf = 1'b0; scan_cyc = N + 1;
        for (int a = 0; a < N; a++) begin
            int y;
            y = int'(oam[a][27:18]);
            if (oam[a][31] && (((line - y) & 1023) < 16)) begin
                if (cnt == S) begin
                    ovf = 1'b1;
                    scan_cyc = a + 2;
                    break;
                end
                slots[cnt*SW +: SW] = {8'(a), 1'b1};
                cnt++;
            end
        end
    endtask

    task automatic run_line(input string tag, input int line, input int done_at, input bit inject);
        logic [287:0] e_slots;
        int e_cnt, e_scan, e_draw, scan_n, draw_n;
        bit e_ovf, ready;
        model(line, e_slots, e_cnt, e_ovf, e_scan);
        if (e_cnt == 0) e_draw = 0;
        else if (done_at != 0 && done_at <= e_cnt + 2) e_draw = done_at;
        else e_draw = e_cnt + 2;
        @(negedge clk);
        bus.line_number = 9'(line);
        bus.line_start  = 1'b1;
        scan_n = 0; draw_n = 0; ready = 1'b0;
        for (int c = 0; c < 400 && !ready; c++) begin
            @(negedge clk);
            bus.line_start  = 1'b0;
            bus.drawer_done = 1'b0;
            if (bus.oam_sel) scan_n++;
            if (bus.drawer_enable) begin
                draw_n++;
                if (draw_n == done_at) bus.drawer_done = 1'b1;
                if (inject && draw_n == 1) bus.line_start = 1'b1;
            end
            if (bus.line_ready) ready = 1'b1;
        end
        chk($sformatf("%s.ready", tag), 288'(ready), 288'(1));
        chk($sformatf("%s.scan_cycles", tag), 288'(scan_n), 288'(e_scan));
        chk($sformatf("%s.draw_cycles", tag), 288'(draw_n), 288'(e_draw));
        chk($sformatf("%s.count", tag), 288'(bus.sprite_count), 288'(e_cnt));
        chk($sformatf("%s.overflow", tag), 288'(bus.overflow), 288'(e_ovf));
        chk($sformatf("%s.slots", tag), 288'(bus.second_array), e_slots);
        chk($sformatf("%s.late_err", tag), 288'(bus.late_err), 288'(inject && e_cnt > 0));
        @(negedge clk);
        chk($sformatf("%s.ready_pulse", tag), 288'({bus.line_ready, bus.busy}), 288'(0));
    endtask

    initial begin
        bus.line_start  = 1'b0;
        bus.line_number = '0;
        bus.drawer_done = 1'b0;
        clear_oam();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset.outs", 288'({bus.busy, bus.oam_sel, bus.oam_a, bus.drawer_enable, bus.line_ready,
                               bus.sprite_count, bus.overflow, bus.late_err}), 288'(0));
        chk("reset.slots", 288'(bus.second_array), 288'(0));

        // Reset mid-SCAN after a few early hits have landed
        for (int a = 0; a < 5; a++) oam[a] = mk(1'b1, 50);
        @(negedge clk);
        bus.line_number = 9'd55;
        bus.line_start  = 1'b1;
        @(negedge clk);
        bus.line_start = 1'b0;
        repeat (20) @(negedge clk);
        chk("midscan.busy", 288'(bus.busy), 288'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midscan.outs", 288'({bus.busy, bus.oam_sel, bus.oam_a, bus.drawer_enable, bus.line_ready,
                                 bus.sprite_count, bus.overflow, bus.late_err}), 288'(0));
        chk("midscan.slots", 288'(bus.second_array), 288'(0));

        clear_oam();
        run_line("empty", 10, 0, 1'b0);

        clear_oam();
        oam[3]  = mk(1'b1, 5);
        oam[70] = mk(1'b1, 20);
        oam[10] = mk(1'b1, 21);
        run_line("two_hits", 20, 3, 1'b0);

        clear_oam();
        oam[7] = mk(1'b1, 470);
        run_line("wrap_miss", 5, 0, 1'b0);
        oam[7] = mk(1'b1, 0);
        run_line("edge_hit", 15, 0, 1'b0);
        run_line("edge_miss", 16, 0, 1'b0);

        clear_oam();
        for (int a = 0; a < 40; a++) oam[a * 3] = mk(1'b1, 95);
        run_line("overflow", 100, 0, 1'b0);

        clear_oam();
        oam[12] = mk(1'b1, 200);
        oam[13] = mk(1'b1, 190);
        run_line("late_set", 201, 0, 1'b1);
        run_line("late_clear", 201, 2, 1'b0);

        for (int t = 0; t < 25; t++) begin
            int line, p;
            clear_oam();
            line = int'($urandom_range(0, 479));
            p = (t % 5 == 0) ? 3 : 1;
            for (int a = 0; a < N; a++)
                if (int'($urandom_range(0, 3)) < p)
                    oam[a] = mk(1'b1, line - int'($urandom_range(0, 20)));
                else if ($urandom_range(0, 1) == 1)
                    oam[a] = mk(1'b1, int'($urandom_range(0, 1023)));
            run_line($sformatf("rand%0d", t), line, int'($urandom_range(0, 40)),
                     $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
